// File: rtl/seven_seg_scan_ctrl_pkg.sv
// seven_seg_scan_ctrl_pkg: state encoding, blank segment code and digit-count limits for the scan controller
package seven_seg_scan_ctrl_pkg;
  typedef enum logic [1:0] {ST_OFF, ST_LIT, ST_GAP} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam int MIN_DIGITS = 2;
  localparam int MAX_DIGITS = 8;
endpackage

// File: rtl/seven_seg_scan_ctrl_converter.sv
// seven_seg_converter: hex nibble to active-high {g..a} segment code; ports hex (in 4), seg (out 7)
module seven_seg_converter (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  localparam logic [15:0][6:0] TABLE = {7'h71, 7'h79, 7'h5e, 7'h39, 7'h7c, 7'h77, 7'h6f, 7'h7f,
                                        7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f};
  assign seg = TABLE[hex];
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: tear-free multiplexed seven-segment scanner; ports clk, rst_n, en, value, upd_req/upd_ack, hex_sel/seg_code (external seven_seg_converter), seg, an_n, frame_tick; option SEVEN_SEG_LZ_BLANK_EN blanks leading zeros
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DWELL_CYC      = 50000,
  parameter int GAP_CYC        = 500,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic [3:0]              hex_sel,
  input  logic [6:0]              seg_code,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2((DWELL_CYC > GAP_CYC ? DWELL_CYC : GAP_CYC) + 1);
  localparam logic [6:0] SEG_OFF = SEG_BLANK ^ {7{SEG_ACTIVE_LOW}};
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS || DWELL_CYC < 2 || GAP_CYC < 1) begin : g_bad_cfg
    $error("seven_seg_scan_ctrl: unsupported parameters");
  end
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nx;
  logic start, take, show;
  logic [6:0] seg_nx;
  logic [NUM_DIGITS-1:0] an_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ST_OFF;
      idx        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      seg        <= SEG_OFF;
      an_n       <= '1;
      upd_ack    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      shadow     <= shadow_nx;
      seg        <= seg_nx;
      an_n       <= an_nx;
      upd_ack    <= take;
      frame_tick <= start;
    end
  // Outputs are registered from the next state, so the decoder is fed the
  // digit about to be lit (including a word captured on this very edge).
  always_comb begin
    state_nx = !en ? ST_OFF :
               state == ST_OFF ? ST_LIT :
               state == ST_LIT ? (cnt == CW'(DWELL_CYC - 1) ? ST_GAP : ST_LIT) :
               (cnt == CW'(GAP_CYC - 1) ? ST_LIT : ST_GAP);
    cnt_nx = (state_nx != state || state_nx == ST_OFF) ? '0 : cnt + 1'b1;
    idx_nx = state_nx == ST_OFF ? '0 :
             (state == ST_GAP && state_nx == ST_LIT) ? (idx == LAST ? '0 : idx + 1'b1) : idx;
    start = state_nx == ST_LIT && state != ST_LIT && idx_nx == '0;
    take = start && upd_req;
    shadow_nx = take ? value : shadow;
    hex_sel = shadow_nx[{idx_nx, 2'b00} +: 4];
  end
  always_comb begin
`ifdef SEVEN_SEG_LZ_BLANK_EN
    show = idx_nx == '0;
    for (int i = 1; i < NUM_DIGITS; i++) show = show | (i >= int'(idx_nx) && shadow_nx[4*i +: 4] != 4'h0);
`else
    show = 1'b1;
`endif
    seg_nx = state_nx == ST_LIT && show ? seg_code ^ {7{SEG_ACTIVE_LOW}} : SEG_OFF;
    an_nx = state_nx == ST_LIT && show ? ~(NUM_DIGITS'(1) << idx_nx) : '1;
  end
endmodule
